dhs_axil_to_apb_bridge: RTL and testbench
=========================================

// Module: dhs_axil_to_apb_bridge
// PURPOSE
//  Single-outstanding AXI4-Lite slave to APB3 master bridge. Sits directly downstream of one Peripheral Link
//  master port (after AXI-to-AXI-Lite conversion) and drives one peripheral APB target (SoC ctrl, UART, CLINT, PLIC).
//  Serialises reads and writes into APB SETUP/ACCESS phases and returns PSLVERR as AXI SLVERR.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max ACCESS-phase cycles before abort (used only with DHS_APB_TIMEOUT_EN); must be >= 2
// PORTS
//  clk_i        in   1                single clock, all logic rising-edge
//  rst_ni       in   1                asynchronous active-low reset
//  axil_req_i   in   dhs_axil_req_t   AW/W/B-ready/AR/R-ready from Peripheral Link port
//  axil_resp_o  out  dhs_axil_resp_t  AW/W/AR ready, B and R channels
//  apb_req_o    out  dhs_apb_req_t    paddr, pprot, psel, penable, pwrite, pwdata, pstrb
//  apb_resp_i   in   dhs_apb_resp_t   pready, prdata, pslverr
// BEHAVIOUR
//  - Reset: all axil_resp_o and apb_req_o fields 0; FSM=IDLE; rr_last=WRITE (first contested grant goes to read).
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; only one transaction in flight.
//  - IDLE: write candidate = aw_valid && w_valid (both required, same cycle). Read candidate = ar_valid.
//    Both pending: grant alternates (opposite of rr_last). Grant pulses aw_ready+w_ready, or ar_ready, for
//    exactly one cycle; captures addr, prot, data, strb; update rr_last; -> SETUP.
//  - aw_valid without w_valid (or vice versa): no handshake and no grant, other direction may proceed.
//  - SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata/pstrb/pprot from capture; -> ACCESS.
//  - ACCESS: psel=1, penable=1, fields stable. On pready: latch prdata, resp = pslverr ? 2'b10 : 2'b00;
//    drop psel/penable next cycle; -> RESP.
//  - pstrb driven with AXI wstrb for writes, 0 for reads; pprot = captured ax_prot.
//  - RESP: write -> b_valid=1, b.resp held until b_ready; read -> r_valid=1, r.data/r.resp held until r_ready.
//    Handshake cycle -> IDLE; new grant possible the following cycle (no same-cycle re-grant).
//  - Latency (zero-wait APB, ready downstream): grant at cycle 0, SETUP 1, ACCESS 2, b/r_valid at cycle 3.
//  - Valid/data on B/R never change while valid && !ready (AXI stability rule).
//  - Bridge never decodes addresses; any address routed to it is forwarded unchanged.
//  - Async reset mid-transaction: immediate abort, psel/penable/valids drop to 0, no response issued.
// CONFIGURATION
//  - Macro DHS_APB_TIMEOUT_EN defined: 16-bit counter clears on SETUP entry and counts ACCESS cycles;
//    when count reaches TIMEOUT_CYCLES-1 without pready, terminate transfer (psel=penable=0 next cycle),
//    respond SLVERR (2'b10), rdata=32'hDEAD_BEEF for reads; late pready afterwards ignored.
//  - Macro undefined: no counter; ACCESS waits indefinitely for pready; no extra flops synthesised.
// STRUCTURE
//  - dual_helix_pkg: reuse dhs_axil_*_t and dhs_apb_*_t; add typedef enum logic [1:0]
//    {BR_IDLE, BR_SETUP, BR_ACCESS, BR_RESP} dhs_apb_br_state_e and localparam DHS_APB_TIMEOUT_RDATA.
//  - No sub-module: FSM, capture registers and optional counter all inline; one instance per APB target.
// TESTING
//  - Read 0x2000_1004, pready tied 1, prdata=32'h0000_00A5 -> SETUP cycle 1, ACCESS cycle 2, r_valid cycle 3, r.data=A5, resp OKAY.
//  - Write 0x2000_0000 data 32'h1234_5678 strb 4'b0011, pready after 3 wait states -> pwdata/pstrb stable all ACCESS cycles, b.resp OKAY.
//  - AW+W+AR all valid in IDLE after reset -> read granted first, then write; next contested pair -> read again (alternation).
//  - pslverr=1 on read -> r.resp=2'b10; b_ready/r_ready held 0 for 5 cycles -> response stable, no new APB transfer.
//  - DHS_APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready never -> psel drops after 8 ACCESS cycles, r.resp=2'b10, r.data=DEAD_BEEF.
//  - rst_ni asserted during ACCESS -> all outputs 0 asynchronously; after release, first read completes normally.

Source files
------------

// File: rtl/dual_helix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_helix_pkg
// Description : Shared AXI4-Lite / APB3 channel structs and bridge FSM types
//               used by the Peripheral Link APB bridges.
// Revision    : 1.0 - initial release
// ============================================================================
package dual_helix_pkg;

    // AXI4-Lite master-to-slave signals (AW, W, B ready, AR, R ready)
    typedef struct packed {
        logic        aw_valid;
        logic [31:0] aw_addr;
        logic [2:0]  aw_prot;
        logic        w_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        b_ready;
        logic        ar_valid;
        logic [31:0] ar_addr;
        logic [2:0]  ar_prot;
        logic        r_ready;
    } dhs_axil_req_t;

    // AXI4-Lite slave-to-master signals (AW/W/AR ready, B and R channels)
    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic        b_valid;
        logic [1:0]  b_resp;
        logic        ar_ready;
        logic        r_valid;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
    } dhs_axil_resp_t;

    // APB3 master outputs
    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } dhs_apb_req_t;

    // APB3 target responses
    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } dhs_apb_resp_t;

    typedef enum logic [1:0] {
        BR_IDLE   = 2'd0,
        BR_SETUP  = 2'd1,
        BR_ACCESS = 2'd2,
        BR_RESP   = 2'd3
    } dhs_apb_br_state_e;

    // Direction of the most recent grant, used for read/write alternation
    typedef enum logic {
        BR_DIR_READ  = 1'b0,
        BR_DIR_WRITE = 1'b1
    } dhs_apb_br_dir_e;

    localparam logic [1:0]  DHS_AXI_RESP_OKAY     = 2'b00;
    localparam logic [1:0]  DHS_AXI_RESP_SLVERR   = 2'b10;
    localparam logic [31:0] DHS_APB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/dhs_axil_to_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dhs_axil_to_apb_bridge
// Description : Single-outstanding AXI4-Lite slave to APB3 master bridge.
//               Serialises reads and writes into APB SETUP/ACCESS phases and
//               returns PSLVERR as AXI SLVERR. Contested read/write requests
//               are granted alternately.
//               Optional macro DHS_APB_TIMEOUT_EN adds an ACCESS-phase
//               watchdog that aborts a transfer after TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dhs_axil_to_apb_bridge
    import dual_helix_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  dhs_axil_req_t  axil_req_i,
    output dhs_axil_resp_t axil_resp_o,
    output dhs_apb_req_t   apb_req_o,
    input  dhs_apb_resp_t  apb_resp_i
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    dhs_apb_br_state_e state_q,    state_d;
    dhs_apb_br_dir_e   rr_last_q,  rr_last_d;
    logic              is_write_q, is_write_d;
    logic [31:0]       addr_q,     addr_d;
    logic [2:0]        prot_q,     prot_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [3:0]        strb_q,     strb_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic [1:0]        resp_q,     resp_d;

    logic wr_cand;
    logic rd_cand;
    logic grant_wr;
    logic grant_rd;

`ifdef DHS_APB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // A write needs address and data together; a lone AW or W never blocks reads
    assign wr_cand = axil_req_i.aw_valid && axil_req_i.w_valid;
    assign rd_cand = axil_req_i.ar_valid;

    // Next-state, arbitration and capture logic
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        prot_d     = prot_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
`ifdef DHS_APB_TIMEOUT_EN
        tmo_cnt_d  = '0;
`endif
        case (state_q)
            BR_IDLE: begin
                if (wr_cand && rd_cand) begin
                    grant_rd = (rr_last_q == BR_DIR_WRITE);
                    grant_wr = (rr_last_q == BR_DIR_READ);
                end else begin
                    grant_wr = wr_cand;
                    grant_rd = rd_cand;
                end
                if (grant_wr) begin
                    is_write_d = 1'b1;
                    addr_d     = axil_req_i.aw_addr;
                    prot_d     = axil_req_i.aw_prot;
                    wdata_d    = axil_req_i.w_data;
                    strb_d     = axil_req_i.w_strb;
                    rr_last_d  = BR_DIR_WRITE;
                    state_d    = BR_SETUP;
                end else if (grant_rd) begin
                    is_write_d = 1'b0;
                    addr_d     = axil_req_i.ar_addr;
                    prot_d     = axil_req_i.ar_prot;
                    wdata_d    = '0;
                    strb_d     = '0;
                    rr_last_d  = BR_DIR_READ;
                    state_d    = BR_SETUP;
                end
            end
            BR_SETUP: begin
                state_d = BR_ACCESS;
            end
            BR_ACCESS: begin
`ifdef DHS_APB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                if (apb_resp_i.pready) begin
                    rdata_d = apb_resp_i.prdata;
                    resp_d  = apb_resp_i.pslverr ? DHS_AXI_RESP_SLVERR : DHS_AXI_RESP_OKAY;
                    state_d = BR_RESP;
                end
`ifdef DHS_APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandon the target; any pready arriving later is never sampled
                    rdata_d = DHS_APB_TIMEOUT_RDATA;
                    resp_d  = DHS_AXI_RESP_SLVERR;
                    state_d = BR_RESP;
                end
`endif
            end
            BR_RESP: begin
                if (is_write_q ? axil_req_i.b_ready : axil_req_i.r_ready) begin
                    state_d = BR_IDLE;
                end
            end
            default: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    // State and capture registers; reset aborts any transfer in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BR_IDLE;
            rr_last_q  <= BR_DIR_WRITE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            prot_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rdata_q    <= '0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            prot_q     <= prot_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
        end
    end

`ifdef DHS_APB_TIMEOUT_EN
    // ACCESS-phase cycle counter, held at zero outside ACCESS
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    // Output decode: APB fields come straight from the capture registers
    always_comb begin
        axil_resp_o          = '0;
        axil_resp_o.aw_ready = grant_wr;
        axil_resp_o.w_ready  = grant_wr;
        axil_resp_o.ar_ready = grant_rd;
        axil_resp_o.b_valid  = (state_q == BR_RESP) && is_write_q;
        axil_resp_o.b_resp   = resp_q;
        axil_resp_o.r_valid  = (state_q == BR_RESP) && !is_write_q;
        axil_resp_o.r_data   = rdata_q;
        axil_resp_o.r_resp   = resp_q;

        apb_req_o            = '0;
        apb_req_o.paddr      = addr_q;
        apb_req_o.pprot      = prot_q;
        apb_req_o.psel       = (state_q == BR_SETUP) || (state_q == BR_ACCESS);
        apb_req_o.penable    = (state_q == BR_ACCESS);
        apb_req_o.pwrite     = is_write_q;
        apb_req_o.pwdata     = wdata_q;
        apb_req_o.pstrb      = strb_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_dhs_axil_to_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dhs_axil_to_apb_bridge
// Description : Self-checking bench for dhs_axil_to_apb_bridge. An AXI-Lite
//               master driver, a behavioural APB peripheral and a reference
//               memory/arbitration model. Timeout scenario runs only when
//               DHS_APB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dhs_axil_to_apb_bridge;
    import dual_helix_pkg::*;

    localparam int TMO = 8;

    logic           clk_i  = 1'b0;
    logic           rst_ni = 1'b0;
    dhs_axil_req_t  axil_req;
    dhs_axil_resp_t axil_resp;
    dhs_apb_req_t   apb_req;
    dhs_apb_resp_t  apb_resp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl_mem [16];
    logic [31:0] slv_mem [16];
    bit          rr_m = 1'b1;          // 1: previous grant was a write
    bit          slv_hang = 1'b0;
    bit          slv_force_err = 1'b0;
    int          slv_wait_cfg = 0;
    int          slv_wait_left = 0;
    logic [31:0] exp_paddr = '0;
    logic [31:0] exp_pwdata = '0;
    logic [2:0]  exp_pprot = '0;
    logic [3:0]  exp_pstrb = '0;
    logic        exp_pwrite = 1'b0;

    dhs_axil_to_apb_bridge #(.TIMEOUT_CYCLES(TMO)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .axil_req_i  (axil_req),
        .axil_resp_o (axil_resp),
        .apb_req_o   (apb_req),
        .apb_resp_i  (apb_resp)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return a[15:12] == 4'hE;
    endfunction

    function automatic logic [31:0] mk_addr();
        logic [31:0] a;
        a        = 32'h2000_0000;
        a[15:12] = ($urandom_range(0, 3) == 0) ? 4'hE : 4'h1;
        a[5:2]   = 4'($urandom_range(0, 15));
        return a;
    endfunction

    // Behavioural APB peripheral plus field monitor, acting on the falling edge
    always @(negedge clk_i) begin
        int  idx;
        bit  err;
        apb_resp.pready  = 1'b0;
        apb_resp.pslverr = 1'b0;
        apb_resp.prdata  = '0;
        if (apb_req.psel) begin
            chk("paddr",  apb_req.paddr, exp_paddr);
            chk("pwrite", 32'(apb_req.pwrite), 32'(exp_pwrite));
            chk("pstrb",  32'(apb_req.pstrb), 32'(exp_pstrb));
            chk("pprot",  32'(apb_req.pprot), 32'(exp_pprot));
            if (exp_pwrite) chk("pwdata", apb_req.pwdata, exp_pwdata);
            if (!apb_req.penable) begin
                slv_wait_left = slv_wait_cfg;
            end else if (!slv_hang) begin
                if (slv_wait_left == 0) begin
                    idx = int'(apb_req.paddr[5:2]);
                    err = addr_err(apb_req.paddr) || slv_force_err;
                    apb_resp.pready  = 1'b1;
                    apb_resp.pslverr = err;
                    apb_resp.prdata  = slv_mem[idx];
                    if (apb_req.pwrite && !err) begin
                        for (int b = 0; b < 4; b++)
                            if (apb_req.pstrb[b]) slv_mem[idx][8*b +: 8] = apb_req.pwdata[8*b +: 8];
                    end
                end else begin
                    slv_wait_left--;
                end
            end
        end
        if (axil_resp.b_valid || axil_resp.r_valid) chk("psel_during_resp", 32'(apb_req.psel), 32'd0);
    end

    // Issue an optional write and/or read together; called and returns on a falling edge
    task automatic run_txn(input bit en_w, input logic [31:0] wa, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [2:0] wp, input int w_delay,
                           input bit en_r, input logic [31:0] ra, input logic [2:0] rp,
                           input int wait_st, input int bp);
        int          cyc, grant_cyc, rsp_wait, active, e_lat;
        bit          pend_w, pend_r, rsp_rdy, wc, rc, err, e_bv, e_rv;
        logic [2:0]  e_grant, g_grant;
        logic [31:0] e_data;
        logic [1:0]  e_resp;
        slv_wait_cfg = wait_st;
        pend_w = en_w; pend_r = en_r; active = 0; cyc = 0; grant_cyc = 0;
        rsp_rdy = (bp == 0); rsp_wait = bp; e_lat = 3; e_data = '0; e_resp = '0;
        axil_req.aw_valid = en_w; axil_req.aw_addr = wa; axil_req.aw_prot = wp;
        axil_req.w_valid  = en_w && (w_delay == 0); axil_req.w_data = wd; axil_req.w_strb = ws;
        axil_req.ar_valid = en_r; axil_req.ar_addr = ra; axil_req.ar_prot = rp;
        axil_req.b_ready  = rsp_rdy; axil_req.r_ready = rsp_rdy;
        while ((pend_w || pend_r || active != 0) && cyc < 100) begin
            #1;
            e_grant = 3'b000;
            if (active == 0) begin
                wc = axil_req.aw_valid && axil_req.w_valid;
                rc = axil_req.ar_valid;
                if (wc && rc)  e_grant = rr_m ? 3'b001 : 3'b110;
                else if (wc)   e_grant = 3'b110;
                else if (rc)   e_grant = 3'b001;
            end
            g_grant = {axil_resp.aw_ready, axil_resp.w_ready, axil_resp.ar_ready};
            chk("grant", 32'(g_grant), 32'(e_grant));
            e_bv = (active == 1) && (cyc - grant_cyc >= e_lat);
            e_rv = (active == 2) && (cyc - grant_cyc >= e_lat);
            chk("b_valid", 32'(axil_resp.b_valid), 32'(e_bv));
            chk("r_valid", 32'(axil_resp.r_valid), 32'(e_rv));
            if (e_bv) chk("b_resp", 32'(axil_resp.b_resp), 32'(e_resp));
            if (e_rv) begin
                chk("r_resp", 32'(axil_resp.r_resp), 32'(e_resp));
                chk("r_data", axil_resp.r_data, e_data);
            end
            // response channel bookkeeping
            if ((active == 1 && axil_resp.b_valid) || (active == 2 && axil_resp.r_valid)) begin
                if (rsp_rdy) begin
                    active = 0;
                end else begin
                    rsp_wait--;
                    if (rsp_wait <= 0) rsp_rdy = 1'b1;
                end
            end
            // request channel handshakes as the DUT performed them
            if (axil_req.aw_valid && axil_resp.aw_ready && axil_req.w_valid && axil_resp.w_ready) begin
                err = addr_err(wa) || slv_force_err || slv_hang;
                active = 1; pend_w = 1'b0; grant_cyc = cyc; rr_m = 1'b1;
                e_resp = err ? 2'b10 : 2'b00;
                if (!err) for (int b = 0; b < 4; b++) if (ws[b]) mdl_mem[wa[5:2]][8*b +: 8] = wd[8*b +: 8];
                exp_paddr = wa; exp_pwrite = 1'b1; exp_pwdata = wd; exp_pstrb = ws; exp_pprot = wp;
                e_lat = slv_hang ? 2 + TMO : 3 + wait_st;
                rsp_rdy = (bp == 0); rsp_wait = bp;
            end else if (axil_req.ar_valid && axil_resp.ar_ready) begin
                err = addr_err(ra) || slv_force_err || slv_hang;
                active = 2; pend_r = 1'b0; grant_cyc = cyc; rr_m = 1'b0;
                e_resp = err ? 2'b10 : 2'b00;
                e_data = slv_hang ? 32'hDEAD_BEEF : mdl_mem[ra[5:2]];
                exp_paddr = ra; exp_pwrite = 1'b0; exp_pstrb = 4'h0; exp_pprot = rp;
                e_lat = slv_hang ? 2 + TMO : 3 + wait_st;
                rsp_rdy = (bp == 0); rsp_wait = bp;
            end
            @(negedge clk_i);
            cyc++;
            axil_req.aw_valid = pend_w;
            axil_req.w_valid  = pend_w && (cyc >= w_delay);
            axil_req.ar_valid = pend_r;
            axil_req.b_ready  = rsp_rdy && (active == 1);
            axil_req.r_ready  = rsp_rdy && (active == 2);
        end
        if (cyc >= 100) chk("txn_cycle_budget", 32'd0, 32'd1);
        axil_req = '0;
    endtask

    initial begin
        logic [31:0] seed_word;
        axil_req = '0;
        for (int i = 0; i < 16; i++) begin
            seed_word  = $urandom;
            mdl_mem[i] = seed_word;
            slv_mem[i] = seed_word;
        end
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_axil_resp_zero", 32'(axil_resp != '0), 32'd0);
        chk("rst_apb_req_zero",   32'(apb_req != '0),   32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        chk("idle_apb_req_zero",  32'(apb_req != '0),   32'd0);
        @(negedge clk_i);

        // Contested pairs right after reset: read first, and again on the next pair
        run_txn(1'b1, 32'h2000_1008, 32'hCAFE_0001, 4'hF, 3'd0, 0, 1'b1, 32'h2000_100C, 3'd1, 0, 0);
        run_txn(1'b1, 32'h2000_1010, 32'hCAFE_0002, 4'hF, 3'd2, 0, 1'b1, 32'h2000_1008, 3'd3, 1, 1);

        // Zero-wait read of a known value
        slv_mem[1] = 32'h0000_00A5; mdl_mem[1] = 32'h0000_00A5;
        run_txn(1'b0, '0, '0, 4'h0, 3'd0, 0, 1'b1, 32'h2000_1004, 3'd0, 0, 0);

        // Partial-strobe write with three wait states, then read it back
        run_txn(1'b1, 32'h2000_0000, 32'h1234_5678, 4'b0011, 3'd5, 0, 1'b0, '0, 3'd0, 3, 0);
        run_txn(1'b0, '0, '0, 4'h0, 3'd0, 0, 1'b1, 32'h2000_0000, 3'd0, 0, 0);

        // PSLVERR on a read with five cycles of response backpressure
        slv_force_err = 1'b1;
        run_txn(1'b0, '0, '0, 4'h0, 3'd0, 0, 1'b1, 32'h2000_1014, 3'd0, 0, 5);
        slv_force_err = 1'b0;

        // AW without W must not be granted; the read goes ahead
        run_txn(1'b1, 32'h2000_1018, 32'h5555_AAAA, 4'hF, 3'd0, 4, 1'b1, 32'h2000_101C, 3'd0, 1, 0);

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            bit ew, er;
            ew = 1'($urandom_range(0, 1));
            er = 1'($urandom_range(0, 1));
            if (!ew && !er) er = 1'b1;
            run_txn(ew, mk_addr(), $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 2), er, mk_addr(), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef DHS_APB_TIMEOUT_EN
        // Target that never answers: aborted with SLVERR and the poison read value
        slv_hang = 1'b1;
        run_txn(1'b0, '0, '0, 4'h0, 3'd0, 0, 1'b1, 32'h2000_1020, 3'd0, 0, 0);
        run_txn(1'b1, 32'h2000_1024, 32'h0BAD_F00D, 4'hF, 3'd0, 0, 1'b0, '0, 3'd0, 0, 2);
        slv_hang = 1'b0;
`endif

        // Asynchronous reset during ACCESS
        slv_hang   = 1'b1;
        exp_paddr  = 32'h2000_1028; exp_pwrite = 1'b0; exp_pstrb = 4'h0; exp_pprot = 3'd2;
        axil_req.ar_valid = 1'b1; axil_req.ar_addr = 32'h2000_1028; axil_req.ar_prot = 3'd2;
        #1;
        chk("rst_test_grant", 32'(axil_resp.ar_ready), 32'd1);
        @(negedge clk_i);
        axil_req.ar_valid = 1'b0;
        @(negedge clk_i);
        #1;
        chk("rst_test_in_access", 32'(apb_req.penable), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_apb_zero",  32'(apb_req != '0),   32'd0);
        chk("async_rst_axil_zero", 32'(axil_resp != '0), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni   = 1'b1;
        rr_m     = 1'b1;
        slv_hang = 1'b0;
        @(negedge clk_i);
        run_txn(1'b0, '0, '0, 4'h0, 3'd0, 0, 1'b1, 32'h2000_1004, 3'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
